// File: rtl/fp_unpack_align.sv
// fp_unpack_align: operand front end of the FP add/sub datapath.
// Unpacks two IEEE 754 singles, orders them by magnitude and right-aligns the
// smaller significand to the larger exponent with guard/round/sticky bits,
// using an iterative shifter of up to SHIFT_STEP positions per cycle.
// Optional build macro FP_ALIGN_FTZ_EN: flush denormal inputs to signed zero.
module fp_unpack_align #(
  parameter int SHIFT_STEP = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [26:0] big_mant,
  output logic [26:0] small_mant,
  output logic [7:0]  exp_big,
  output logic        sign_big,
  output logic        eff_sub,
  output logic        swapped,
  output logic        is_nan,
  output logic        is_inf
);

  typedef enum logic [1:0] {IDLE, UNPACK, SHIFT, DONE} state_t;

  localparam logic [4:0] STEP = 5'(SHIFT_STEP);

  state_t      r_state, w_state_nxt;
  logic [31:0] r_a, r_b;
  logic        r_op;
  logic [4:0]  r_rem;
  logic [26:0] r_big_mant, r_small_mant;
  logic [7:0]  r_exp_big;
  logic        r_sign_big, r_eff_sub, r_swapped, r_is_nan, r_is_inf;

  logic [7:0]  w_exp_a, w_exp_b, w_eexp_a, w_eexp_b, w_eexp_big, w_eexp_small, w_d;
  logic [22:0] w_frac_a, w_frac_b;
  logic [23:0] w_sig_a, w_sig_b, w_sig_big, w_sig_small;
  logic        w_swap, w_nan_a, w_nan_b, w_inf_a, w_inf_b;
  logic        w_eff_sub, w_sign_big, w_nan, w_inf, w_special, w_far;
  logic [4:0]  w_k;
  logic [26:0] w_shifted, w_small_nxt;
  logic        w_lost;

  // Field extraction, magnitude ordering and special-value classification.
  always_comb begin
    // NOTE: every combinational output gets a value on every path first, so no latches are inferred.
    w_exp_a  = r_a[30:23];
    w_frac_a = r_a[22:0];
    w_exp_b  = r_b[30:23];
    w_frac_b = r_b[22:0];
`ifdef FP_ALIGN_FTZ_EN
    if (w_exp_a == 8'd0) w_frac_a = '0;
    if (w_exp_b == 8'd0) w_frac_b = '0;
`endif
    w_eexp_a  = (w_exp_a == 8'd0) ? 8'd1 : w_exp_a;
    w_eexp_b  = (w_exp_b == 8'd0) ? 8'd1 : w_exp_b;
    w_sig_a   = {w_exp_a != 8'd0, w_frac_a};
    w_sig_b   = {w_exp_b != 8'd0, w_frac_b};
    // Ties keep A as the larger operand.
    w_swap    = {w_exp_b, w_frac_b} > {w_exp_a, w_frac_a};
    w_nan_a   = (w_exp_a == 8'hFF) && (w_frac_a != '0);
    w_nan_b   = (w_exp_b == 8'hFF) && (w_frac_b != '0);
    w_inf_a   = (w_exp_a == 8'hFF) && (w_frac_a == '0);
    w_inf_b   = (w_exp_b == 8'hFF) && (w_frac_b == '0);
    w_eff_sub = r_a[31] ^ r_b[31] ^ r_op;
    w_nan     = w_nan_a || w_nan_b || (w_inf_a && w_inf_b && w_eff_sub);
    w_inf     = (w_inf_a || w_inf_b) && !w_nan;
    w_special = w_nan || w_inf;
    w_sign_big   = w_swap ? (r_b[31] ^ r_op) : r_a[31];
    w_eexp_big   = w_swap ? w_eexp_b : w_eexp_a;
    w_eexp_small = w_swap ? w_eexp_a : w_eexp_b;
    w_sig_big    = w_swap ? w_sig_b : w_sig_a;
    w_sig_small  = w_swap ? w_sig_a : w_sig_b;
    w_d   = w_eexp_big - w_eexp_small;
    w_far = (w_d >= 8'd27);
  end

  // One shifter step: move right by min(STEP, remaining), folding lost bits into sticky.
  always_comb begin
    w_k         = (r_rem < STEP) ? r_rem : STEP;
    w_lost      = |(r_small_mant & ~({27{1'b1}} << w_k));
    w_shifted   = r_small_mant >> w_k;
    w_small_nxt = {w_shifted[26:1], w_shifted[0] | w_lost};
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_nxt = UNPACK;
      UNPACK:  w_state_nxt = (w_special || w_d == 8'd0 || w_far) ? DONE : SHIFT;
      SHIFT:   if (r_rem == w_k) w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Operand capture, unpack results and iterative alignment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= 1'b0;
      r_rem        <= '0;
      r_big_mant   <= '0;
      r_small_mant <= '0;
      r_exp_big    <= '0;
      r_sign_big   <= 1'b0;
      r_eff_sub    <= 1'b0;
      r_swapped    <= 1'b0;
      r_is_nan     <= 1'b0;
      r_is_inf     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_a  <= A;
          r_b  <= B;
          r_op <= op;
        end
        UNPACK: begin
          r_big_mant   <= {w_sig_big, 3'b000};
          r_small_mant <= (w_far && !w_special) ? {26'd0, |w_sig_small}
                                                : {w_sig_small, 3'b000};
          r_rem        <= w_d[4:0];
          r_exp_big    <= w_eexp_big;
          r_sign_big   <= w_sign_big;
          r_eff_sub    <= w_eff_sub;
          r_swapped    <= w_swap;
          r_is_nan     <= w_nan;
          r_is_inf     <= w_inf;
        end
        SHIFT: begin
          r_small_mant <= w_small_nxt;
          r_rem        <= r_rem - w_k;
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = (r_state == IDLE);
  assign out_valid  = (r_state == DONE);
  assign big_mant   = r_big_mant;
  assign small_mant = r_small_mant;
  assign exp_big    = r_exp_big;
  assign sign_big   = r_sign_big;
  assign eff_sub    = r_eff_sub;
  assign swapped    = r_swapped;
  assign is_nan     = r_is_nan;
  assign is_inf     = r_is_inf;

endmodule

// File: tb/tb_fp_unpack_align.sv
// tb_fp_unpack_align: scoreboard bench for fp_unpack_align. Two instances
// (SHIFT_STEP=4 and SHIFT_STEP=1) see the same operands; expected results come
// from a one-shot alignment model and are popped at each output handshake.
module tb_fp_unpack_align;

  typedef struct {
    logic [26:0] bm;
    logic [26:0] sm;
    logic [7:0]  ex;
    logic        sign, sub, swp, nan, inf;
    logic        chk_mant;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] A = '0, B = '0;
  logic        op = 1'b0;
  logic        in_valid0 = 1'b0, in_valid1 = 1'b0;
  logic        out_ready0 = 1'b1, out_ready1 = 1'b1;
  logic        in_ready0, in_ready1, out_valid0, out_valid1;
  logic [26:0] big_mant0, small_mant0, big_mant1, small_mant1;
  logic [7:0]  exp_big0, exp_big1;
  logic        sign_big0, eff_sub0, swapped0, is_nan0, is_inf0;
  logic        sign_big1, eff_sub1, swapped1, is_nan1, is_inf1;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int t_acc = 0;
  int lat0 = 0, lat1 = 0;
  logic seen0 = 1'b0, seen1 = 1'b0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fp_unpack_align #(.SHIFT_STEP(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .A(A), .B(B), .op(op), .out_valid(out_valid0), .out_ready(out_ready0),
    .big_mant(big_mant0), .small_mant(small_mant0), .exp_big(exp_big0),
    .sign_big(sign_big0), .eff_sub(eff_sub0), .swapped(swapped0),
    .is_nan(is_nan0), .is_inf(is_inf0)
  );

  fp_unpack_align #(.SHIFT_STEP(1)) u_dut_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .A(A), .B(B), .op(op), .out_valid(out_valid1), .out_ready(out_ready1),
    .big_mant(big_mant1), .small_mant(small_mant1), .exp_big(exp_big1),
    .sign_big(sign_big1), .eff_sub(eff_sub1), .swapped(swapped1),
    .is_nan(is_nan1), .is_inf(is_inf1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Reference: classify, order, then align in a single wide shift.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic o, input int step);
    exp_t r;
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        na, nb, ia, ib;
    int          xa, xb, d;
    logic [26:0] xs, mask;
    ea = a[30:23]; fa = a[22:0];
    eb = b[30:23]; fb = b[22:0];
`ifdef FP_ALIGN_FTZ_EN
    if (ea == 8'd0) fa = '0;
    if (eb == 8'd0) fb = '0;
`endif
    na = (ea == 8'hFF) && (fa != 0);
    nb = (eb == 8'hFF) && (fb != 0);
    ia = (ea == 8'hFF) && (fa == 0);
    ib = (eb == 8'hFF) && (fb == 0);
    r.sub = a[31] ^ b[31] ^ o;
    r.swp = ({eb, fb} > {ea, fa});
    r.nan = na || nb || (ia && ib && r.sub);
    r.inf = (ia || ib) && !r.nan;
    xa = (ea == 8'd0) ? 1 : int'(ea);
    xb = (eb == 8'd0) ? 1 : int'(eb);
    if (r.swp) begin
      r.ex = 8'(xb); r.sign = b[31] ^ o;
      r.bm = {eb != 8'd0, fb, 3'b000}; xs = {ea != 8'd0, fa, 3'b000}; d = xb - xa;
    end else begin
      r.ex = 8'(xa); r.sign = a[31];
      r.bm = {ea != 8'd0, fa, 3'b000}; xs = {eb != 8'd0, fb, 3'b000}; d = xa - xb;
    end
    r.chk_mant = !(na || nb || ia || ib);
    if (d >= 27) r.sm = {26'd0, |xs};
    else begin
      mask = (27'd1 << d) - 27'd1;
      r.sm = (xs >> d) | {26'd0, |(xs & mask)};
    end
    r.lat = (!r.chk_mant || d == 0 || d >= 27) ? 2 : 2 + (d + step - 1) / step;
    return r;
  endfunction

  task automatic compare(input string who, input exp_t e, input int lat,
                         input logic [26:0] bm, input logic [26:0] sm, input logic [7:0] ex,
                         input logic [4:0] flags);
    if (e.chk_mant) begin
      check({who, "_big_mant"}, 64'(bm), 64'(e.bm));
      check({who, "_small_mant"}, 64'(sm), 64'(e.sm));
    end
    check({who, "_exp_big"}, 64'(ex), 64'(e.ex));
    check({who, "_flags(sign,sub,swp,nan,inf)"}, 64'(flags),
          64'({e.sign, e.sub, e.swp, e.nan, e.inf}));
    check({who, "_latency"}, 64'(lat), 64'(e.lat));
  endtask

  // Output monitor, SHIFT_STEP=4 instance.
  always @(negedge clk) begin
    #1;
    if (!rst_n) seen0 = 1'b0;
    else if (out_valid0) begin
      if (!seen0) begin seen0 = 1'b1; lat0 = cyc - t_acc + 1; end
      if (out_ready0) begin
        check("s4_expected_pending", 64'(q0.size() != 0), 64'd1);
        if (q0.size() != 0)
          compare("s4", q0.pop_front(), lat0, big_mant0, small_mant0, exp_big0,
                  {sign_big0, eff_sub0, swapped0, is_nan0, is_inf0});
        seen0 = 1'b0;
      end
    end
  end

  // Output monitor, SHIFT_STEP=1 instance.
  always @(negedge clk) begin
    #1;
    if (!rst_n) seen1 = 1'b0;
    else if (out_valid1) begin
      if (!seen1) begin seen1 = 1'b1; lat1 = cyc - t_acc + 1; end
      if (out_ready1) begin
        check("s1_expected_pending", 64'(q1.size() != 0), 64'd1);
        if (q1.size() != 0)
          compare("s1", q1.pop_front(), lat1, big_mant1, small_mant1, exp_big1,
                  {sign_big1, eff_sub1, swapped1, is_nan1, is_inf1});
        seen1 = 1'b0;
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic o);
    @(negedge clk);
    check("in_ready_before_accept", 64'({in_ready0, in_ready1}), 64'd3);
    A = a; B = b; op = o;
    in_valid0 = 1'b1; in_valid1 = 1'b1;
    q0.push_back(model(a, b, o, 4));
    q1.push_back(model(a, b, o, 1));
    @(posedge clk);
    #1;
    t_acc = cyc;
    in_valid0 = 1'b0; in_valid1 = 1'b0;
    A = $urandom; B = $urandom; op = 1'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
    check("drain_timeout", 64'(q0.size() + q1.size()), 64'd0);
  endtask

  task automatic txn(input logic [31:0] a, input logic [31:0] b, input logic o);
    send(a, b, o);
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   n;
    logic [31:0] ra, rb;

    repeat (2) @(negedge clk);
    #1;
    check("reset_handshake(in_ready,out_valid)", 64'({in_ready0, out_valid0}), 64'b10);
    check("reset_data", 64'({big_mant0, small_mant0, exp_big0, sign_big0, eff_sub0,
                            swapped0, is_nan0, is_inf0}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    txn(32'h3F800000, 32'h40000000, 1'b0);
    txn(32'h3F800000, 32'h3F800000, 1'b1);
    txn(32'h4B800000, 32'h3F800001, 1'b0);
    txn(32'h50000000, 32'h3F800000, 1'b0);
    txn(32'h7F800000, 32'h7F800000, 1'b1);
    txn(32'h7F800000, 32'h3F800000, 1'b0);
    txn(32'h3F800000, 32'h00000001, 1'b0);
    txn(32'h00000010, 32'h00000001, 1'b1);
    txn(32'h7FC00000, 32'h3F800000, 1'b0);
    txn(32'hC0400000, 32'h40A00000, 1'b1);
    txn(32'h3F800000, 32'hBF800000, 1'b0);
    txn(32'h80000000, 32'h00000000, 1'b0);
    txn(32'h3F800000, 32'h3E800000, 1'b0);
    txn(32'h41000000, 32'h3F7FFFFF, 1'b1);

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      rb[30:23] = ra[30:23] - 8'($urandom_range(0, 30));
      txn(ra, rb, 1'($urandom));
    end

    // Backpressure on the SHIFT_STEP=4 instance; in_valid pulses while stalled must be ignored.
    e = model(32'h3F800000, 32'h40000000, 1'b0, 4);
    out_ready0 = 1'b0;
    send(32'h3F800000, 32'h40000000, 1'b0);
    n = 0;
    while (!out_valid0 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("bp_out_valid", 64'(out_valid0), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid0 = 1'b1;
      A = $urandom;
      #1;
      check("bp_hold_handshake(out_valid,in_ready)", 64'({out_valid0, in_ready0}), 64'b10);
      check("bp_hold_mants", 64'({big_mant0, small_mant0}), 64'({e.bm, e.sm}));
      check("bp_hold_exp", 64'(exp_big0), 64'(e.ex));
    end
    @(negedge clk);
    in_valid0 = 1'b0;
    out_ready0 = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release(out_valid,in_ready)", 64'({out_valid0, in_ready0}), 64'b01);
    drain();

    // Reset during SHIFT discards the transaction.
    send(32'h4B800000, 32'h3F800001, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_handshake(out_valid0,in_ready0,out_valid1,in_ready1)",
          64'({out_valid0, in_ready0, out_valid1, in_ready1}), 64'b0101);
    check("midrst_small_mant", 64'(small_mant0), 64'd0);
    q0.delete();
    q1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    txn(32'h4B800000, 32'h3F800001, 1'b0);
    txn(32'h3F800000, 32'h40000000, 1'b1);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
